// File: rtl/if_fetch_pkg.sv
// rtl/if_fetch_pkg.sv - shared widths, constants and fetch-state encodings for if_fetch
package if_fetch_pkg;

  localparam int ADDR_LEN = 32;
  localparam int INST_LEN = 32;
  localparam logic RESET_ENABLE = 1'b1;
  localparam logic [INST_LEN-1:0] ZERO_WORD = '0;

  typedef enum logic [2:0] {
    IF_IDLE = 3'd0,
    IF_S0   = 3'd1,
    IF_S1   = 3'd2,
    IF_S2   = 3'd3,
    IF_S3   = 3'd4,
    IF_S4   = 3'd5,
    IF_DONE = 3'd6
  } if_state_e;

  // Byte offset from pc driven onto the RAM address in each address phase.
  function automatic logic [1:0] fetch_offset(input if_state_e s);
    case (s)
      IF_S1:   fetch_offset = 2'd1;
      IF_S2:   fetch_offset = 2'd2;
      IF_S3:   fetch_offset = 2'd3;
      default: fetch_offset = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/if_icache.sv
// rtl/if_icache.sv - direct-mapped instruction cache: combinational lookup, synchronous fill and valid clear
// Instantiated by if_fetch only when ICACHE_EN is defined.
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int IDX_W = 5,
  parameter int TAG_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IDX_W-1:0]    lookup_idx,
  input  logic [TAG_W-1:0]    lookup_tag,
  output logic                hit,
  output logic [INST_LEN-1:0] rdata,
  input  logic                fill_en,
  input  logic [IDX_W-1:0]    fill_idx,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [INST_LEN-1:0] fill_data
);

  localparam int ENTRIES = 1 << IDX_W;

  logic [ENTRIES-1:0]  valid_q;
  logic [TAG_W-1:0]    tag_q  [ENTRIES];
  logic [INST_LEN-1:0] data_q [ENTRIES];

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      valid_q <= '0;
    end else if (fill_en) begin
      valid_q[fill_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data;
    end
  end

  assign hit   = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);
  assign rdata = data_q[lookup_idx];

endmodule

// File: rtl/if_fetch.sv
// rtl/if_fetch.sv - instruction fetch: four little-endian byte reads per word into the IF/ID register
// Optional instruction cache enabled by defining ICACHE_EN.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_LEN-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                  ICACHE_IDX_W = 5,
  parameter int                  ICACHE_TAG_W = 11
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                stall_or_not,
  input  logic                jump_en,
  input  logic [ADDR_LEN-1:0] jump_addr,
  input  logic                mem_grant,
  input  logic [7:0]          mem_din,
  output logic                mem_rd,
  output logic [ADDR_LEN-1:0] mem_a,
  output logic [ADDR_LEN-1:0] if_pc,
  output logic [INST_LEN-1:0] if_inst,
  output logic                if_stall_req
);

  if_state_e           state_q, state_d;
  logic [ADDR_LEN-1:0] pc_q, pc_d;
  logic [ADDR_LEN-1:0] if_pc_q, if_pc_d;
  logic [INST_LEN-1:0] if_inst_q, if_inst_d;
  logic                stall_q, stall_d;
  logic [23:0]         part_q, part_d;
  logic [ADDR_LEN-1:0] pc_inc;
  logic                cache_hit;
  logic [INST_LEN-1:0] cache_data;

  assign pc_inc = pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      state_q <= IF_IDLE;
    end else if (rdy) begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (jump_en) begin
      state_d = IF_IDLE;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (cache_hit)      state_d = IF_DONE;
          else if (mem_grant) state_d = IF_S0;
        end
        IF_S0:   state_d = IF_S1;
        IF_S1:   state_d = IF_S2;
        IF_S2:   state_d = IF_S3;
        IF_S3:   state_d = IF_S4;
        IF_S4:   state_d = IF_DONE;
        IF_DONE: begin
          if (!stall_or_not) begin
            if (cache_hit)      state_d = IF_DONE;
            else if (mem_grant) state_d = IF_S0;
            else                state_d = IF_IDLE;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_rd = 1'b0;
    mem_a  = '0;
    case (state_q)
      IF_S0, IF_S1, IF_S2, IF_S3: begin
        mem_rd = 1'b1;
        mem_a  = pc_q + {{(ADDR_LEN-2){1'b0}}, fetch_offset(state_q)};
      end
      default: ;
    endcase
  end

  // RAM data lags its address by one cycle, so byte k lands in state S(k+1).
  always_comb begin
    pc_d      = pc_q;
    if_pc_d   = if_pc_q;
    if_inst_d = if_inst_q;
    stall_d   = stall_q;
    part_d    = part_q;
    if (jump_en) begin
      pc_d      = jump_addr;
      part_d    = '0;
      stall_d   = 1'b1;
      if_inst_d = ZERO_WORD;
    end else begin
      case (state_q)
        IF_IDLE: begin
          if (cache_hit) begin
            if_inst_d = cache_data;
            if_pc_d   = pc_q;
            stall_d   = 1'b0;
          end
        end
        IF_S1: part_d[7:0]   = mem_din;
        IF_S2: part_d[15:8]  = mem_din;
        IF_S3: part_d[23:16] = mem_din;
        IF_S4: begin
          if_inst_d = {mem_din, part_q};
          if_pc_d   = pc_q;
          stall_d   = 1'b0;
        end
        IF_DONE: begin
          if (!stall_or_not) begin
            pc_d = pc_inc;
            if (cache_hit) begin
              if_inst_d = cache_data;
              if_pc_d   = pc_inc;
              stall_d   = 1'b0;
            end else begin
              stall_d = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RESET_ENABLE) begin
      pc_q      <= RESET_PC;
      if_pc_q   <= '0;
      if_inst_q <= ZERO_WORD;
      stall_q   <= 1'b1;
      part_q    <= '0;
    end else if (rdy) begin
      pc_q      <= pc_d;
      if_pc_q   <= if_pc_d;
      if_inst_q <= if_inst_d;
      stall_q   <= stall_d;
      part_q    <= part_d;
    end
  end

  assign if_pc        = if_pc_q;
  assign if_inst      = if_inst_q;
  assign if_stall_req = stall_q;

`ifdef ICACHE_EN
  localparam int TagLsb = 2 + ICACHE_IDX_W;

  logic [ICACHE_IDX_W-1:0] lookup_idx;
  logic [ICACHE_TAG_W-1:0] lookup_tag;
  logic                    fill_en;

  // In DONE the lookup targets the instruction after the one being consumed.
  assign lookup_idx = (state_q == IF_DONE) ? pc_inc[TagLsb-1:2] : pc_q[TagLsb-1:2];
  assign lookup_tag = (state_q == IF_DONE) ? pc_inc[TagLsb+ICACHE_TAG_W-1:TagLsb]
                                           : pc_q[TagLsb+ICACHE_TAG_W-1:TagLsb];
  assign fill_en    = rdy && !jump_en && (state_q == IF_S4);

  if_icache #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (ICACHE_TAG_W)
  ) u_icache (
    .clk        (clk),
    .rst        (rst),
    .lookup_idx (lookup_idx),
    .lookup_tag (lookup_tag),
    .hit        (cache_hit),
    .rdata      (cache_data),
    .fill_en    (fill_en),
    .fill_idx   (pc_q[TagLsb-1:2]),
    .fill_tag   (pc_q[TagLsb+ICACHE_TAG_W-1:TagLsb]),
    .fill_data  ({mem_din, part_q})
  );
`else
  assign cache_hit  = 1'b0;
  assign cache_data = ZERO_WORD;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// tb/tb_if_fetch.sv - directed self-checking bench for if_fetch with a byte RAM model
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst, rdy, stall_or_not, jump_en, mem_grant;
  logic [31:0] jump_addr;
  logic [7:0]  mem_din = 8'h00;
  logic        mem_rd;
  logic [31:0] mem_a, if_pc, if_inst;
  logic        if_stall_req;

  logic [7:0]  ram [1024];
  int          n_checks = 0;
  int          n_errors = 0;

  if_fetch dut (
    .clk          (clk),
    .rst          (rst),
    .rdy          (rdy),
    .stall_or_not (stall_or_not),
    .jump_en      (jump_en),
    .jump_addr    (jump_addr),
    .mem_grant    (mem_grant),
    .mem_din      (mem_din),
    .mem_rd       (mem_rd),
    .mem_a        (mem_a),
    .if_pc        (if_pc),
    .if_inst      (if_inst),
    .if_stall_req (if_stall_req)
  );

  always #5 clk = ~clk;

  // RAM shares the global rdy stall with the fetch unit.
  always @(posedge clk) if (rdy) mem_din <= ram[mem_a[9:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic load_word(input int addr, input logic [31:0] w);
    ram[addr]   = w[7:0];
    ram[addr+1] = w[15:8];
    ram[addr+2] = w[23:16];
    ram[addr+3] = w[31:24];
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd"},    {31'd0, mem_rd}, 32'd0);
    check({tag, "_a"},     mem_a, 32'd0);
    check({tag, "_pc"},    if_pc, 32'd0);
    check({tag, "_inst"},  if_inst, 32'd0);
    check({tag, "_stall"}, {31'd0, if_stall_req}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    load_word(32'h000, 32'h0010_0513);
    load_word(32'h004, 32'h0010_0093);
    load_word(32'h100, 32'h0034_12b7);
    load_word(32'h104, 32'h00b5_0533);
    load_word(32'h3fc, 32'h0000_006f);

    rst = 1'b1; rdy = 1'b1; stall_or_not = 1'b0; jump_en = 1'b0;
    jump_addr = 32'h0; mem_grant = 1'b0;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      tick();
      check("nogrant_rd", {31'd0, mem_rd}, 32'd0);
      check("nogrant_stall", {31'd0, if_stall_req}, 32'd1);
    end
    mem_grant = 1'b1;

    tick();
    check("f0_s0_rd", {31'd0, mem_rd}, 32'd1);
    check("f0_s0_a", mem_a, 32'h0);
    stall_or_not = 1'b1;
    tick(); check("f0_s1_a", mem_a, 32'h1);
    tick(); check("f0_s2_a", mem_a, 32'h2);
    tick(); check("f0_s3_a", mem_a, 32'h3);
    tick(); check("f0_s4_rd", {31'd0, mem_rd}, 32'd0);
    tick();
    check("f0_inst", if_inst, 32'h0010_0513);
    check("f0_pc", if_pc, 32'h0);
    check("f0_valid", {31'd0, if_stall_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_inst", if_inst, 32'h0010_0513);
      check("hold_pc", if_pc, 32'h0);
      check("hold_rd", {31'd0, mem_rd}, 32'd0);
    end
    stall_or_not = 1'b0;

    tick();
    check("f1_s0_rd", {31'd0, mem_rd}, 32'd1);
    check("f1_s0_a", mem_a, 32'h4);
    check("f1_bubble", {31'd0, if_stall_req}, 32'd1);
    tick(); tick(); tick(); tick(); tick();
    check("f1_inst", if_inst, 32'h0010_0093);
    check("f1_pc", if_pc, 32'h4);

    tick(); check("f2_s0_a", mem_a, 32'h8);
    tick(); tick();
    jump_en = 1'b1; jump_addr = 32'h100;
    tick();
    jump_en = 1'b0;
    check("jmp_rd", {31'd0, mem_rd}, 32'd0);
    check("jmp_stall", {31'd0, if_stall_req}, 32'd1);
    check("jmp_inst", if_inst, 32'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      check("jmp_a", mem_a, 32'h100 + k);
    end
    tick(); tick();
    check("f3_inst", if_inst, 32'h0034_12b7);
    check("f3_pc", if_pc, 32'h100);

    tick(); check("f4_s0_a", mem_a, 32'h104);
    tick(); check("f4_s1_a", mem_a, 32'h105);
    rdy = 1'b0;
    tick(); check("rdy_a", mem_a, 32'h105);
    check("rdy_rd", {31'd0, mem_rd}, 32'd1);
    tick(); check("rdy_a2", mem_a, 32'h105);
    rdy = 1'b1;
    tick(); check("f4_s2_a", mem_a, 32'h106);
    tick(); check("f4_s3_a", mem_a, 32'h107);
    tick(); tick();
    check("f4_inst", if_inst, 32'h00b5_0533);
    check("f4_pc", if_pc, 32'h104);
    jump_en = 1'b1; jump_addr = 32'hffff_fffc;

    tick();
    jump_en = 1'b0;
    check("jc_stall", {31'd0, if_stall_req}, 32'd1);
    check("jc_inst", if_inst, 32'h0);
    tick(); check("f5_s0_a", mem_a, 32'hffff_fffc);
    tick(); tick();
    tick(); check("f5_s3_a", mem_a, 32'hffff_ffff);
    tick(); tick();
    check("f5_inst", if_inst, 32'h0000_006f);
    check("f5_pc", if_pc, 32'hffff_fffc);
    tick();
    check("wrap_a", mem_a, 32'h0);
    check("wrap_rd", {31'd0, mem_rd}, 32'd1);
    tick();
    rst = 1'b1;
    tick();
    check_reset("midrst");
    rst = 1'b0;
    tick();
    check("rst_s0_a", mem_a, 32'h0);
    check("rst_s0_rd", {31'd0, mem_rd}, 32'd1);
    stall_or_not = 1'b1;
    tick(); tick(); tick(); tick(); tick();
    check("f6_inst", if_inst, 32'h0010_0513);

`ifdef ICACHE_EN
    jump_en = 1'b1; jump_addr = 32'h0;
    tick();
    jump_en = 1'b0;
    check("hit_idle_rd", {31'd0, mem_rd}, 32'd0);
    tick();
    check("hit_rd", {31'd0, mem_rd}, 32'd0);
    check("hit_valid", {31'd0, if_stall_req}, 32'd0);
    check("hit_inst", if_inst, 32'h0010_0513);
    check("hit_pc", if_pc, 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
